// File: rtl/freq_sel_decoder_if.sv
// Select-decoder bus: mux output in, decoded code out.
// err_cnt exists only when FSD_ERR_CNT_EN is defined.
interface freq_sel_decoder_if;
  logic       Y;
  logic [1:0] sel;
  logic       valid;
  logic       sel_chg;
`ifdef FSD_ERR_CNT_EN
  logic [7:0] err_cnt;

  modport master (
    output Y,
    input  sel, valid, sel_chg, err_cnt
  );
  modport slave (
    input  Y,
    output sel, valid, sel_chg, err_cnt
  );
`else
  modport master (
    output Y,
    input  sel, valid, sel_chg
  );
  modport slave (
    input  Y,
    output sel, valid, sel_chg
  );
`endif
endinterface

// File: rtl/freq_sel_decoder.sv
// Recovers a 2-bit select code from a square wave's half-period.
// Optional FSD_ERR_CNT_EN adds a saturating miss/timeout counter.
module freq_sel_decoder #(
  parameter int HP0    = 500,
  parameter int HP1    = 250,
  parameter int HP2    = 125,
  parameter int HP3    = 62,
  parameter int TOL_SH = 3,
  parameter int LOCK_N = 4,
  parameter int CNT_W  = 10
) (
  input  logic clk,
  input  logic rst,
  freq_sel_decoder_if.slave bus
);

  localparam int MW = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] LO0 = CNT_W'(HP0 - (HP0 >> TOL_SH));
  localparam logic [CNT_W-1:0] HI0 = CNT_W'(HP0 + (HP0 >> TOL_SH));
  localparam logic [CNT_W-1:0] LO1 = CNT_W'(HP1 - (HP1 >> TOL_SH));
  localparam logic [CNT_W-1:0] HI1 = CNT_W'(HP1 + (HP1 >> TOL_SH));
  localparam logic [CNT_W-1:0] LO2 = CNT_W'(HP2 - (HP2 >> TOL_SH));
  localparam logic [CNT_W-1:0] HI2 = CNT_W'(HP2 + (HP2 >> TOL_SH));
  localparam logic [CNT_W-1:0] LO3 = CNT_W'(HP3 - (HP3 >> TOL_SH));
  localparam logic [CNT_W-1:0] HI3 = CNT_W'(HP3 + (HP3 >> TOL_SH));
  localparam logic [CNT_W-1:0] TMO = HI0;
  localparam logic [MW-1:0]    LCK = MW'(LOCK_N);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  state_t           state, state_n;
  logic             s1, s2, s3;
  logic             tog, tmo, hit;
  logic [3:0]       win;
  logic [1:0]       cls;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cand, cand_n;
  logic [MW-1:0]    mcnt, mcnt_n, mc_new;
  logic [1:0]       sel_r, sel_n;
  logic             valid_r, valid_n;
  logic             chg_r, chg_n;

  assign tog = s2 ^ s3;
  assign tmo = !tog && (state != IDLE) && (cnt > TMO);

  assign win[0] = (cnt >= LO0) && (cnt <= HI0);
  assign win[1] = (cnt >= LO1) && (cnt <= HI1);
  assign win[2] = (cnt >= LO2) && (cnt <= HI2);
  assign win[3] = (cnt >= LO3) && (cnt <= HI3);
  assign hit    = |win;

  // Lowest matching class wins if windows ever overlap.
  always_comb begin
    cls = 2'd0;
    priority case (1'b1)
      win[0]:  cls = 2'd0;
      win[1]:  cls = 2'd1;
      win[2]:  cls = 2'd2;
      win[3]:  cls = 2'd3;
      default: cls = 2'd0;
    endcase
  end

  // Synchronize Y and keep a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.Y;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Half-period counter: restarts at 1 on each edge, saturates.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (tog)
      cnt <= CNT_W'(1);
    else if (cnt != '1)
      cnt <= cnt + 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cand    <= 2'd0;
      mcnt    <= '0;
      sel_r   <= 2'd0;
      valid_r <= 1'b0;
      chg_r   <= 1'b0;
    end else begin
      state   <= state_n;
      cand    <= cand_n;
      mcnt    <= mcnt_n;
      sel_r   <= sel_n;
      valid_r <= valid_n;
      chg_r   <= chg_n;
    end
  end

  // Next-state logic: acquire, lock, drop on mismatch or timeout.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    mcnt_n  = mcnt;
    sel_n   = sel_r;
    valid_n = valid_r;
    chg_n   = 1'b0;
    mc_new  = (cls == cand) ? mcnt + 1'b1 : MW'(1);
    unique case (state)
      IDLE: begin
        if (tog) begin
          state_n = ACQ;
          mcnt_n  = '0;
        end
      end
      ACQ: begin
        if (tog && hit) begin
          cand_n = cls;
          mcnt_n = mc_new;
          if (mc_new == LCK) begin
            sel_n   = cls;
            valid_n = 1'b1;
            chg_n   = 1'b1;
            state_n = LOCK;
          end
        end else if (tog) begin
          mcnt_n = '0;
        end
      end
      LOCK: begin
        if (tog && hit && cls != sel_r) begin
          valid_n = 1'b0;
          cand_n  = cls;
          mcnt_n  = MW'(1);
          state_n = ACQ;
        end else if (tog && !hit) begin
          valid_n = 1'b0;
          mcnt_n  = '0;
          state_n = ACQ;
        end
      end
      default: state_n = IDLE;
    endcase
    if (tmo) begin
      valid_n = 1'b0;
      mcnt_n  = '0;
      state_n = IDLE;
    end
  end

  assign bus.sel     = sel_r;
  assign bus.valid   = valid_r;
  assign bus.sel_chg = chg_r;

`ifdef FSD_ERR_CNT_EN
  logic [7:0] err;
  logic       err_inc;

  assign err_inc = (tog && !hit && state != IDLE) || tmo;

  // Saturating count of unclassifiable half-periods and timeouts.
  always_ff @(posedge clk) begin
    if (rst)
      err <= 8'd0;
    else if (err_inc && err != 8'hFF)
      err <= err + 8'd1;
  end

  assign bus.err_cnt = err;
`endif

endmodule
